// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between the multi-cycle sequencer and the datapath
// plus shared memory port.
//   master  : the sequencer (drives every enable/select, fault and retire count)
//   slave   : datapath/memory side (drives opcode/funct, alu_zero, mem_ready)
// Signals: instr_op/instr_func (IR fields from the read bus), alu_zero,
// mem_ready, mem_req/mem_we/mem_addr_sel, ir_write, pc_write/pc_src,
// reg_write/reg_dst/mem_to_reg, alu_src/alu_op, fault/fault_cause, retired.
interface multicycle_sequencer_if #(
  parameter int RETIRE_WIDTH = 32
);
  logic [5:0]              instr_op;
  logic [5:0]              instr_func;
  logic                    alu_zero;
  logic                    mem_ready;
  logic                    mem_req;
  logic                    mem_we;
  logic                    mem_addr_sel;
  logic                    ir_write;
  logic                    pc_write;
  logic [1:0]              pc_src;
  logic                    reg_write;
  logic [1:0]              reg_dst;
  logic [1:0]              mem_to_reg;
  logic [1:0]              alu_src;
  logic [2:0]              alu_op;
  logic                    fault;
  logic [1:0]              fault_cause;
  logic [RETIRE_WIDTH-1:0] retired;

  modport master (
    input  instr_op, instr_func, alu_zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, alu_src, alu_op,
           fault, fault_cause, retired
  );

  modport slave (
    output instr_op, instr_func, alu_zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, alu_src, alu_op,
           fault, fault_cause, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer. Walks each instruction through
// FETCH/DECODE/EXEC/[MEM]/[WB] with a bounded memory wait counter, counts
// retired instructions and traps illegal opcodes / memory timeouts.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : multicycle_sequencer_if.master (all control/status signals)
// Outputs are decoded from state plus latched opcode/funct; FETCH ir/pc
// writes follow mem_ready and beq pc_write follows alu_zero in the same cycle.
module multicycle_sequencer #(
  parameter int MAX_WAIT     = 15,
  parameter int RETIRE_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

  state_t                  state_q;
  logic [5:0]              op_q, fn_q;
  logic [WW-1:0]           wait_q;
  logic [RETIRE_WIDTH-1:0] retired_q;
  logic [1:0]              cause_q;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, legal;

  assign is_addu = (op_q == OP_R) && (fn_q == FN_ADDU);
  assign is_subu = (op_q == OP_R) && (fn_q == FN_SUBU);
  assign is_jr   = (op_q == OP_R) && (fn_q == FN_JR);
  assign is_ori  = (op_q == OP_ORI);
  assign is_lui  = (op_q == OP_LUI);
  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_beq  = (op_q == OP_BEQ);
  assign is_j    = (op_q == OP_J);
  assign is_jal  = (op_q == OP_JAL);
  assign legal   = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw |
                   is_sw | is_beq | is_j | is_jal;

  // Every path back to FETCH clears the wait counter; the three retiring
  // exits (EXEC, MEM, WB) also bump the retire count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          wait_q  <= '0;
        end
        S_FETCH: begin
          if (bus.mem_ready) begin
            op_q    <= bus.instr_op;
            fn_q    <= bus.instr_func;
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LIM) begin
            state_q <= S_FAULT;
            cause_q <= 2'b10;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            state_q <= S_FAULT;
            cause_q <= 2'b01;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_lw || is_sw) begin
            state_q <= S_MEM;
            wait_q  <= '0;
          end else if (is_addu || is_subu || is_ori || is_lui) begin
            state_q <= S_WB;
          end else begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= retired_q + 1'b1;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_sw) begin
              state_q   <= S_FETCH;
              wait_q    <= '0;
              retired_q <= retired_q + 1'b1;
            end else begin
              state_q <= S_WB;
            end
          end else if (wait_q == WAIT_LIM) begin
            state_q <= S_FAULT;
            cause_q <= 2'b10;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          wait_q    <= '0;
          retired_q <= retired_q + 1'b1;
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = 2'b00;
    bus.reg_write    = 1'b0;
    bus.reg_dst      = 2'b00;
    bus.mem_to_reg   = 2'b00;
    bus.alu_src      = 2'b00;
    bus.alu_op       = 3'b000;
    bus.fault        = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_EXEC: begin
        if (is_subu)             bus.alu_op = 3'b001;
        if (is_ori)  begin bus.alu_src = 2'b01; bus.alu_op = 3'b010; end
        if (is_lui)  begin bus.alu_src = 2'b01; bus.alu_op = 3'b011; end
        if (is_lw || is_sw)      bus.alu_src = 2'b10;
        if (is_beq) begin
          bus.alu_op   = 3'b001;
          bus.pc_src   = 2'b01;
          bus.pc_write = bus.alu_zero;
        end
        if (is_j || is_jal) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b10;
        end
        if (is_jal) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'b10;
          bus.mem_to_reg = 2'b10;
        end
        if (is_jr) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b11;
        end
      end
      S_MEM: begin
        // address path held on the ALU for the whole access
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.alu_src      = 2'b10;
        bus.mem_we       = is_sw;
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        if (is_lw)              bus.mem_to_reg = 2'b01;
        if (is_addu || is_subu) bus.reg_dst    = 2'b01;
      end
      S_FAULT: bus.fault = 1'b1;
      default: ;
    endcase
  end

  assign bus.fault_cause = cause_q;
  assign bus.retired     = retired_q;

endmodule
